broadcast_controller: RTL and testbench
=======================================

BROADCAST_CONTROLLER -- requirements
Module: broadcast_controller

Interface
REQ-001 The block SHALL have parameter PARTICLE_ID_WIDTH, default 7, giving the width of particle IDs and counts.
REQ-002 The block SHALL have parameter COUNT_DELAY, default 3, giving the cycles from start until particle_count is valid.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL be clocked on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle pulse that begins broadcast of one cell.
REQ-006 The block SHALL have port particle_count, input, PARTICLE_ID_WIDTH, the number of particles in the cell.
REQ-007 The block SHALL have port broadcast_done, input, 1, the combinational done flag from the done checker, computed on particle_id.
REQ-008 The block SHALL have port stall, input, 1, downstream backpressure.
REQ-009 The block SHALL have port particle_id, output, PARTICLE_ID_WIDTH, the current read ID, driving the cell memory and the done checker.
REQ-010 The block SHALL have port rd_en, output, 1, the cell memory read strobe.
REQ-011 The block SHALL have port particle_valid, output, 1, marking that cell-memory read data is valid.
REQ-012 The block SHALL have port valid_id, output, PARTICLE_ID_WIDTH, the ID belonging to particle_valid.
REQ-013 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT_CNT, BCAST, DRAIN and FINISH.
REQ-016 IDLE with start=1 SHALL:
- go to WAIT_CNT;
- load particle_id=1;
- clear the delay counter.
REQ-017 WAIT_CNT SHALL count COUNT_DELAY cycles, then leave as follows:
- particle_count==0: go to FINISH, issuing no reads;
- otherwise: go to BCAST.
REQ-018 In BCAST with stall=0 and broadcast_done=0, the block SHALL:
- assert rd_en combinationally for that cycle;
- increment particle_id at the clock edge.
REQ-019 In BCAST with stall=1, the block SHALL hold rd_en=0 and particle_id unchanged.
REQ-020 In BCAST with broadcast_done=1, the block SHALL hold rd_en=0 and go to DRAIN; broadcast_done SHALL take priority over stall.
REQ-021 In BCAST, an issued read with particle_id equal to all-ones SHALL go to DRAIN without incrementing, so particle_id never wraps to 0.
REQ-022 DRAIN SHALL last exactly one cycle and then go to FINISH.
REQ-023 FINISH SHALL assert done for one cycle and then go to IDLE.
REQ-024 particle_valid SHALL equal rd_en delayed by one cycle, and valid_id SHALL equal the particle_id registered with that read (memory read latency 1).
REQ-025 For a count N between 1 and 2^W-2, exactly N reads SHALL be issued, with IDs 1..N in ascending order.
REQ-026 start SHALL be ignored whenever busy=1.
REQ-027 A start arriving in the same cycle as done SHALL be ignored; start is accepted only in IDLE.
REQ-028 Changes to particle_count after WAIT_CNT SHALL take effect only through broadcast_done.

Reset
REQ-029 Assertion of rst_n=0 SHALL asynchronously force:
- state = IDLE;
- particle_id = 0, valid_id = 0;
- rd_en, particle_valid, busy, done = 0;
- delay counter = 0.
REQ-030 A reset asserted mid-broadcast SHALL abandon the broadcast; no done pulse and no further particle_valid SHALL follow.
REQ-031 After reset release, the block SHALL stay in IDLE until a start pulse arrives.

Configuration
REQ-032 With BROADCAST_STALL_EN defined, the stall input SHALL behave as in REQ-019.
REQ-033 Without BROADCAST_STALL_EN, the stall port SHALL be retained but ignored, and BCAST SHALL issue a read on every cycle until broadcast_done.

Verification
REQ-034 Scenario: particle_count=5, no stall, start pulse ->
- rd_en high for 5 consecutive cycles beginning 4 cycles after start;
- valid_id sequence 1..5;
- done pulse 2 cycles after the last particle_valid.
REQ-035 Scenario: particle_count=0, start pulse ->
- no rd_en and no particle_valid;
- done 4 cycles after start;
- busy high for 4 cycles.
REQ-036 Scenario: particle_count=4, stall high for 2 cycles after the 2nd read (BROADCAST_STALL_EN defined) ->
- IDs 1..4 exactly once each, with a 2-cycle gap;
- the same stimulus without the macro gives no gap.
REQ-037 Scenario: particle_count=126 (PARTICLE_ID_WIDTH=7) ->
- 126 reads;
- the last valid_id is 126;
- particle_id never reads 0 while busy.
REQ-038 Scenario: rst_n pulsed low during the 3rd read of count=10 ->
- all outputs 0 immediately;
- no done pulse;
- a subsequent start broadcasts IDs 1..10.
REQ-039 Scenario: start re-pulsed mid-broadcast and again in the done cycle -> both pulses ignored, and exactly one done pulse results.

Source files
------------

// File: rtl/broadcast_controller.sv
`default_nettype none
// ============================================================================
// Module   : broadcast_controller
// Purpose  : Walks particle IDs 1..N of one cell into the cell memory and
//            flags the returned read data. `BROADCAST_STALL_EN honours stall.
// Revision : 1.0  initial release
// ============================================================================
module broadcast_controller #(
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int COUNT_DELAY       = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [PARTICLE_ID_WIDTH-1:0] particle_count,
    input  logic                         broadcast_done,
    input  logic                         stall,
    output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
    output logic                         rd_en,
    output logic                         particle_valid,
    output logic [PARTICLE_ID_WIDTH-1:0] valid_id,
    output logic                         busy,
    output logic                         done
);

    localparam logic [2:0] c_idle     = 3'd0;
    localparam logic [2:0] c_wait_cnt = 3'd1;
    localparam logic [2:0] c_bcast    = 3'd2;
    localparam logic [2:0] c_drain    = 3'd3;
    localparam logic [2:0] c_finish   = 3'd4;

    localparam int                           c_cnt_w    = (COUNT_DELAY > 1) ? $clog2(COUNT_DELAY) : 1;
    localparam logic [c_cnt_w-1:0]           c_cnt_last = c_cnt_w'(COUNT_DELAY - 1);
    localparam logic [PARTICLE_ID_WIDTH-1:0] c_id_max   = '1;

    logic [2:0]                   r_state;
    logic [2:0]                   w_state_nxt;
    logic [PARTICLE_ID_WIDTH-1:0] r_particle_id;
    logic [PARTICLE_ID_WIDTH-1:0] w_particle_id_nxt;
    logic [c_cnt_w-1:0]           r_delay_cnt;
    logic [c_cnt_w-1:0]           w_delay_cnt_nxt;
    logic                         r_particle_valid;
    logic [PARTICLE_ID_WIDTH-1:0] r_valid_id;
    logic                         w_rd_en;
    logic                         w_stall;

`ifdef BROADCAST_STALL_EN
    assign w_stall = stall;
`else
    // Port kept for pin compatibility; reads are never held back.
    logic w_unused_stall;
    assign w_unused_stall = stall;
    assign w_stall        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= c_idle;
            r_particle_id    <= '0;
            r_delay_cnt      <= '0;
            r_particle_valid <= 1'b0;
            r_valid_id       <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_particle_id    <= w_particle_id_nxt;
            r_delay_cnt      <= w_delay_cnt_nxt;
            r_particle_valid <= w_rd_en;
            if (w_rd_en) begin
                r_valid_id <= r_particle_id;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_particle_id_nxt = r_particle_id;
        w_delay_cnt_nxt   = r_delay_cnt;
        w_rd_en           = 1'b0;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt       = c_wait_cnt;
                    w_particle_id_nxt = PARTICLE_ID_WIDTH'(1);
                    w_delay_cnt_nxt   = '0;
                end
            end
            c_wait_cnt: begin
                if (r_delay_cnt == c_cnt_last) begin
                    w_state_nxt = (particle_count == '0) ? c_finish : c_bcast;
                end else begin
                    w_delay_cnt_nxt = r_delay_cnt + c_cnt_w'(1);
                end
            end
            c_bcast: begin
                // The done checker wins over backpressure.
                if (broadcast_done) begin
                    w_state_nxt = c_drain;
                end else if (!w_stall) begin
                    w_rd_en = 1'b1;
                    if (r_particle_id == c_id_max) begin
                        w_state_nxt = c_drain;
                    end else begin
                        w_particle_id_nxt = r_particle_id + PARTICLE_ID_WIDTH'(1);
                    end
                end
            end
            c_drain:  w_state_nxt = c_finish;
            c_finish: w_state_nxt = c_idle;
            default:  w_state_nxt = c_idle;
        endcase
    end

    assign particle_id    = r_particle_id;
    assign rd_en          = w_rd_en;
    assign particle_valid = r_particle_valid;
    assign valid_id       = r_valid_id;
    assign busy           = (r_state != c_idle);
    assign done           = (r_state == c_finish);

endmodule
`default_nettype wire

// File: tb/tb_broadcast_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_broadcast_controller
// Purpose  : Randomised self-checking bench with a cycle-level behavioural
//            model of the broadcast timeline. Honours `BROADCAST_STALL_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_broadcast_controller;

    localparam int W     = 7;
    localparam int D     = 3;
    localparam int MAXID = (1 << W) - 1;
`ifdef BROADCAST_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         stall = 1'b0;
    logic [W-1:0] particle_count = '0;
    logic         broadcast_done;
    logic [W-1:0] particle_id;
    logic         rd_en;
    logic         particle_valid;
    logic [W-1:0] valid_id;
    logic         busy;
    logic         done;
    int           cell_count = 0;

    // Done checker of the surrounding system: all IDs of the cell issued.
    assign broadcast_done = (int'(particle_id) > cell_count);

    always #5 clk = ~clk;

    broadcast_controller #(
        .PARTICLE_ID_WIDTH (W),
        .COUNT_DELAY       (D)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .particle_count (particle_count),
        .broadcast_done (broadcast_done),
        .stall          (stall),
        .particle_id    (particle_id),
        .rd_en          (rd_en),
        .particle_valid (particle_valid),
        .valid_id       (valid_id),
        .busy           (busy),
        .done           (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: a broadcast is a wait of D cycles, then N reads interleaved with
    // stall cycles, then a fixed tail of busy cycles ending in the done cycle.
    bit m_active;
    bit m_id_zero;
    int m_wait_left;
    int m_tail;
    int m_reads;
    int m_n;
    bit m_prev_rd;
    int m_prev_id;

    int st_rd, st_pv, st_done, st_busy, st_first_rd, st_last_rd;
    int st_last_pv, st_done_cyc, st_accept, st_last_vid;
    bit st_zero_id;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_zero(input string name);
        check({name, "_particle_id"}, particle_id, 0);
        check({name, "_valid_id"}, valid_id, 0);
        check({name, "_rd_en"}, rd_en, 0);
        check({name, "_particle_valid"}, particle_valid, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
    endtask

    task automatic model_reset();
        m_active    = 1'b0;
        m_id_zero   = 1'b1;
        m_wait_left = 0;
        m_tail      = 0;
        m_reads     = 0;
        m_n         = 0;
        m_prev_rd   = 1'b0;
        m_prev_id   = 0;
    endtask

    task automatic clr_stats();
        st_rd = 0; st_pv = 0; st_done = 0; st_busy = 0;
        st_first_rd = -1; st_last_rd = -1; st_last_pv = -1;
        st_done_cyc = -1; st_accept = -1; st_last_vid = -1;
        st_zero_id = 1'b0;
    endtask

    // Called at posedge+1 with inputs driven; compares at the negedge,
    // advances the model, and returns at the next posedge+1.
    task automatic cycle();
        logic e_rd;
        logic e_done;
        int   e_id;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
            check_zero("in_reset");
        end else begin
            e_id   = m_id_zero ? 0 : ((m_reads + 1 > MAXID) ? MAXID : m_reads + 1);
            e_rd   = m_active && (m_wait_left == 0) && (m_tail == 0) && !(STALL_EN && stall);
            e_done = m_active && (m_tail == 1);
            check("busy", busy, m_active);
            check("particle_id", particle_id, e_id);
            check("rd_en", rd_en, e_rd);
            check("done", done, e_done);
            check("particle_valid", particle_valid, m_prev_rd);
            if (m_prev_rd) check("valid_id", valid_id, m_prev_id);

            if (rd_en) begin
                st_rd++;
                if (st_first_rd < 0) st_first_rd = cyc;
                st_last_rd = cyc;
            end
            if (particle_valid) begin
                st_pv++;
                st_last_pv  = cyc;
                st_last_vid = int'(valid_id);
            end
            if (done) begin
                st_done++;
                st_done_cyc = cyc;
            end
            if (busy) st_busy++;
            if (busy && particle_id == '0) st_zero_id = 1'b1;

            m_prev_rd = e_rd;
            if (e_rd) m_prev_id = e_id;
            if (!m_active) begin
                if (start) begin
                    m_active    = 1'b1;
                    m_id_zero   = 1'b0;
                    m_wait_left = D;
                    m_tail      = 0;
                    m_reads     = 0;
                    st_accept   = cyc;
                end
            end else if (m_wait_left > 0) begin
                m_wait_left--;
                if (m_wait_left == 0) begin
                    m_n = int'(particle_count);
                    if (m_n == 0) m_tail = 1;
                end
            end else if (m_tail > 0) begin
                m_tail--;
                if (m_tail == 0) m_active = 1'b0;
            end else if (e_rd) begin
                m_reads++;
                // Done-check cycle (absent at all-ones), drain, finish.
                if (m_reads == m_n) m_tail = (m_n == MAXID) ? 2 : 3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 1'b0;
        stall = 1'b0;
        repeat (n) cycle();
    endtask

    // mode 0: quiet, 1: random stall/stray start/count scramble,
    // 2: stall two cycles after 2nd read, 3: start mid-run and in done cycle.
    task automatic run_cell(input int n, input int mode, input int reset_at);
        int k;
        clr_stats();
        cell_count     = n;
        particle_count = W'(n);
        stall          = 1'b0;
        start          = 1'b1;
        cycle();
        start = 1'b0;
        k     = 0;
        while (m_active && k < 1000) begin
            k++;
            stall = (mode == 1) ? ($urandom_range(0, 2) == 0) : (mode == 2 && (k == 6 || k == 7));
            start = (mode == 1) ? ($urandom_range(0, 5) == 0) : (mode == 3 && (k == 5 || k == n + 6));
            if (mode == 1 && k >= D + 1) particle_count = W'($urandom);
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("async_reset");
                cycle();
                rst_n = 1'b1;
                break;
            end
            cycle();
        end
        start          = 1'b0;
        stall          = 1'b0;
        particle_count = W'(n);
        check("finished_in_budget", m_active, 0);
    endtask

    initial begin
        int n;
        model_reset();
        clr_stats();
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check_zero("reset_values");
        rst_n = 1'b1;
        idle(3);

        run_cell(5, 0, 0);
        check("n5_reads", st_rd, 5);
        check("n5_first_rd_latency", st_first_rd - st_accept, 4);
        check("n5_rd_span", st_last_rd - st_first_rd, 4);
        check("n5_last_valid_id", st_last_vid, 5);
        check("n5_done_after_last_valid", st_done_cyc - st_last_pv, 2);
        check("n5_done_pulses", st_done, 1);
        idle(2);

        run_cell(0, 0, 0);
        check("n0_reads", st_rd, 0);
        check("n0_valids", st_pv, 0);
        check("n0_done_latency", st_done_cyc - st_accept, 4);
        check("n0_busy_cycles", st_busy, 4);
        idle(2);

        run_cell(4, 2, 0);
        check("n4_stall_reads", st_rd, 4);
        check("n4_stall_rd_span", st_last_rd - st_first_rd, STALL_EN ? 5 : 3);
        check("n4_stall_last_valid_id", st_last_vid, 4);
        idle(2);

        run_cell(126, 0, 0);
        check("n126_reads", st_rd, 126);
        check("n126_last_valid_id", st_last_vid, 126);
        check("n126_no_zero_id", st_zero_id, 0);
        idle(2);

        run_cell(MAXID, 0, 0);
        check("nmax_reads", st_rd, MAXID);
        check("nmax_last_valid_id", st_last_vid, MAXID);
        check("nmax_no_zero_id", st_zero_id, 0);
        idle(2);

        run_cell(10, 0, 6);
        idle(10);
        check("rst_reads_before_abort", st_rd, 2);
        check("rst_valids_after_abort", st_pv, 1);
        check("rst_no_done", st_done, 0);
        run_cell(10, 0, 0);
        check("rst_rerun_reads", st_rd, 10);
        check("rst_rerun_last_valid_id", st_last_vid, 10);
        idle(2);

        run_cell(5, 3, 0);
        idle(4);
        check("restart_done_pulses", st_done, 1);
        check("restart_reads", st_rd, 5);

        for (int i = 0; i < 20; i++) begin
            n = $urandom_range(0, MAXID);
            run_cell(n, 1, 0);
            check("rand_reads", st_rd, n);
            check("rand_done_pulses", st_done, 1);
            idle($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
